// File: rtl/quad_paddle_tracker.sv
// quad_paddle_tracker
// Turns one player's raw quadrature encoder pins into a saturating paddle
// position. The pins are synchronized and glitch-filtered, legal Gray-code
// steps are decoded into +/-STEP moves, and a copy of the position is taken
// on each frame tick so the renderer never sees the paddle move mid-frame.
//
// Ports:
//   clk          system pixel clock
//   rst_n        asynchronous active-low reset
//   quad_a       raw encoder phase A (asynchronous)
//   quad_b       raw encoder phase B (asynchronous)
//   frame_tick   one-cycle pulse per frame from the sync generator
//   pos_live     tracked position, moves on every legal step
//   paddle_pos   position snapshot taken on frame_tick
//   pos_valid    one-cycle pulse when paddle_pos takes a snapshot
//   dir          direction of the last legal step (1 = up)
//   illegal_step one-cycle pulse when both phases changed together
//   err_count    saturating count of illegal steps (QUAD_ERR_CNT_EN only)
//
// Optional feature macro: QUAD_ERR_CNT_EN adds the err_count output.
module quad_paddle_tracker #(
  parameter int POS_W    = 9,
  parameter int POS_MIN  = 0,
  parameter int POS_MAX  = 440,
  parameter int POS_INIT = 200,
  parameter int STEP     = 10,
  parameter int FILT_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             frame_tick,
  output logic [POS_W-1:0] pos_live,
  output logic [POS_W-1:0] paddle_pos,
  output logic             pos_valid,
  output logic             dir,
  output logic             illegal_step
`ifdef QUAD_ERR_CNT_EN
  ,
  output logic [7:0]       err_count
`endif
);

  localparam int CntW = $clog2(FILT_LEN + 1) + 1;

  localparam logic [POS_W:0]   MaxExt     = (POS_W + 1)'(POS_MAX);
  localparam logic [POS_W:0]   LowLimExt  = (POS_W + 1)'(POS_MIN + STEP);
  localparam logic [POS_W:0]   StepExt    = (POS_W + 1)'(STEP);
  localparam logic [POS_W-1:0] MinNarrow  = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0] MaxNarrow  = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] InitNarrow = POS_W'(POS_INIT);
  localparam logic [POS_W-1:0] StepNarrow = POS_W'(STEP);

  typedef enum logic {SEED, TRACK} state_t;

  logic [1:0]       syncMeta_q, syncOut_q;
  logic [1:0]       trackAb_q, trackAb_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [1:0]       acc_q, acc_d;
  logic             accValid_q, accValid_d;
  logic             accStb_q, accStb_d;
  logic             pending;
  state_t           state_q;
  logic [1:0]       prevAb_q;
  logic [POS_W-1:0] pos_q, paddle_q;
  logic             dir_q, illegal_q, valid_q;
  logic [1:0]       stepDelta;
  logic [POS_W:0]   upSum;
  logic [POS_W-1:0] upPos, downPos;

  // Two-flop synchronizer, both phases packed as {A,B}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncMeta_q <= 2'b00;
      syncOut_q  <= 2'b00;
    end else begin
      syncMeta_q <= {quad_a, quad_b};
      syncOut_q  <= syncMeta_q;
    end
  end

  // A candidate is pending while it differs from the accepted value, or
  // while nothing has been accepted yet so the very first pin state can seed.
  // trackAb_q remembers last cycle's candidate; any change restarts the count.
  assign pending = !accValid_q || (syncOut_q != acc_q);

  always_comb begin
    trackAb_d  = syncOut_q;
    cnt_d      = '0;
    acc_d      = acc_q;
    accValid_d = accValid_q;
    accStb_d   = 1'b0;
    if (pending) begin
      if (syncOut_q != trackAb_q) begin
        cnt_d = CntW'(1);
      end else if (cnt_q == CntW'(FILT_LEN)) begin
        acc_d      = syncOut_q;
        accValid_d = 1'b1;
        accStb_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trackAb_q  <= 2'b00;
      cnt_q      <= '0;
      acc_q      <= 2'b00;
      accValid_q <= 1'b0;
      accStb_q   <= 1'b0;
    end else begin
      trackAb_q  <= trackAb_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      accValid_q <= accValid_d;
      accStb_q   <= accStb_d;
    end
  end

  // Gray-to-binary turns the up sequence 00,01,11,10 into 0,1,2,3, so the
  // modulo-4 difference is 1 for up, 3 for down and 2 for a double-bit jump.
  function automatic logic [1:0] gray2bin(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  assign stepDelta = gray2bin(acc_q) - gray2bin(prevAb_q);

  // Saturation uses one extra bit so pos+STEP cannot wrap before the clamp.
  assign upSum   = {1'b0, pos_q} + StepExt;
  assign upPos   = (upSum > MaxExt) ? MaxNarrow : upSum[POS_W-1:0];
  assign downPos = ({1'b0, pos_q} < LowLimExt) ? MinNarrow : (pos_q - StepNarrow);

  // Step-tracking FSM: SEED swallows the first accepted value so reset
  // release never produces a move; TRACK decodes every later change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SEED;
      prevAb_q  <= 2'b00;
      pos_q     <= InitNarrow;
      dir_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      if (accStb_q) begin
        prevAb_q <= acc_q;
        case (state_q)
          SEED: state_q <= TRACK;
          TRACK: begin
            case (stepDelta)
              2'd1: begin
                pos_q <= upPos;
                dir_q <= 1'b1;
              end
              2'd3: begin
                pos_q <= downPos;
                dir_q <= 1'b0;
              end
              2'd2: illegal_q <= 1'b1;
              default: ;
            endcase
          end
          default: state_q <= SEED;
        endcase
      end
    end
  end

  // Frame snapshot takes the position as it stood before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paddle_q <= InitNarrow;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= frame_tick;
      if (frame_tick) begin
        paddle_q <= pos_q;
      end
    end
  end

`ifdef QUAD_ERR_CNT_EN
  logic [7:0] errCnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errCnt_q <= 8'd0;
    end else if (illegal_q && (errCnt_q != 8'hFF)) begin
      errCnt_q <= errCnt_q + 8'd1;
    end
  end

  assign err_count = errCnt_q;
`endif

  assign pos_live     = pos_q;
  assign paddle_pos   = paddle_q;
  assign pos_valid    = valid_q;
  assign dir          = dir_q;
  assign illegal_step = illegal_q;

endmodule

// File: tb/tb_quad_paddle_tracker.sv
// tb_quad_paddle_tracker
// Self-checking bench for quad_paddle_tracker with default parameters.
// A behavioural model tracks the encoder phase as an index into the up
// sequence and applies saturating +/-STEP arithmetic; each scenario task
// drives pins and compares DUT outputs against that model.
module tb_quad_paddle_tracker;

  localparam int POS_W    = 9;
  localparam int POS_MIN  = 0;
  localparam int POS_MAX  = 440;
  localparam int POS_INIT = 200;
  localparam int STEP     = 10;
  localparam int FILT_LEN = 4;
  localparam int LAT      = 2 + FILT_LEN + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             quad_a = 1'b1;
  logic             quad_b = 1'b1;
  logic             frame_tick = 1'b0;
  logic [POS_W-1:0] pos_live;
  logic [POS_W-1:0] paddle_pos;
  logic             pos_valid;
  logic             dir;
  logic             illegal_step;
`ifdef QUAD_ERR_CNT_EN
  logic [7:0]       err_count;
`endif

  int total = 0;
  int bad = 0;
  int illPulses = 0;

  int         modelPos = POS_INIT;
  logic       modelDir = 1'b0;
  int         modelErr = 0;
  logic [1:0] modelAb = 2'b11;
  logic [1:0] upSeq [0:3] = '{2'b00, 2'b01, 2'b11, 2'b10};

  quad_paddle_tracker #(
    .POS_W(POS_W), .POS_MIN(POS_MIN), .POS_MAX(POS_MAX),
    .POS_INIT(POS_INIT), .STEP(STEP), .FILT_LEN(FILT_LEN)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .quad_a(quad_a),
    .quad_b(quad_b),
    .frame_tick(frame_tick),
    .pos_live(pos_live),
    .paddle_pos(paddle_pos),
    .pos_valid(pos_valid),
    .dir(dir),
    .illegal_step(illegal_step)
`ifdef QUAD_ERR_CNT_EN
    ,
    .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  // Count illegal_step pulses observed away from the active edge.
  always @(negedge clk) begin
    if (illegal_step === 1'b1) illPulses++;
  end

  function automatic int seq_idx(input logic [1:0] ab);
    for (int i = 0; i < 4; i++) begin
      if (upSeq[i] == ab) return i;
    end
    return 0;
  endfunction

  // One pin move held for 'hold' cycles; checks the exact update latency.
  task automatic do_step(input logic [1:0] ab, input int hold);
    int d;
    int oldPos;
    int ill0;
    logic wantIll;
    d = (seq_idx(ab) - seq_idx(modelAb) + 4) % 4;
    oldPos = modelPos;
    wantIll = (d == 2);
    if (d == 1) begin
      modelPos = (modelPos + STEP > POS_MAX) ? POS_MAX : modelPos + STEP;
      modelDir = 1'b1;
    end else if (d == 3) begin
      modelPos = (modelPos - STEP < POS_MIN) ? POS_MIN : modelPos - STEP;
      modelDir = 1'b0;
    end else if (d == 2) begin
      modelErr = (modelErr >= 255) ? 255 : modelErr + 1;
    end
    modelAb = ab;
    ill0 = illPulses;
    quad_a = ab[1];
    quad_b = ab[0];
    repeat (LAT) @(negedge clk);
    total++;
    if (pos_live !== POS_W'(oldPos)) begin
      bad++;
      $display("[TB] FAIL latency_hold: pos_live=%0d want=%0d", pos_live, oldPos);
    end
    @(negedge clk);
    total++;
    if (pos_live !== POS_W'(modelPos)) begin
      bad++;
      $display("[TB] FAIL pos_step ab=%b: pos_live=%0d want=%0d", ab, pos_live, modelPos);
    end
    total++;
    if (dir !== modelDir) begin
      bad++;
      $display("[TB] FAIL dir ab=%b: dir=%0b want=%0b", ab, dir, modelDir);
    end
    total++;
    if (illegal_step !== wantIll) begin
      bad++;
      $display("[TB] FAIL illegal_pulse ab=%b: got=%0b want=%0b", ab, illegal_step, wantIll);
    end
    repeat (hold - LAT - 1) @(negedge clk);
    total++;
    if ((illPulses - ill0) !== int'(wantIll)) begin
      bad++;
      $display("[TB] FAIL illegal_count: got=%0d want=%0d", illPulses - ill0, wantIll);
    end
`ifdef QUAD_ERR_CNT_EN
    total++;
    if (err_count !== 8'(modelErr)) begin
      bad++;
      $display("[TB] FAIL err_count: got=%0d want=%0d", err_count, modelErr);
    end
`endif
  endtask

  task automatic test_reset;
    quad_a = 1'b1;
    quad_b = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    total++;
    if (pos_live !== POS_W'(POS_INIT) || paddle_pos !== POS_W'(POS_INIT)) begin
      bad++;
      $display("[TB] FAIL reset_pos: pos_live=%0d paddle=%0d want=%0d", pos_live, paddle_pos, POS_INIT);
    end
    total++;
    if (pos_valid !== 1'b0 || dir !== 1'b0 || illegal_step !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags: valid=%0b dir=%0b ill=%0b want=000", pos_valid, dir, illegal_step);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    total++;
    if (pos_live !== POS_W'(POS_INIT) || illPulses !== 0) begin
      bad++;
      $display("[TB] FAIL seed_11: pos_live=%0d ill=%0d want=%0d,0", pos_live, illPulses, POS_INIT);
    end
    modelAb = 2'b11;
    modelPos = POS_INIT;
    modelDir = 1'b0;
    modelErr = 0;
  endtask

  task automatic test_reset_midop;
    int ill0;
    do_step(2'b10, 12);
    do_step(2'b00, 12);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (pos_live !== POS_W'(POS_INIT) || dir !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midop_reset: pos_live=%0d dir=%0b want=%0d,0", pos_live, dir, POS_INIT);
    end
    quad_a = 1'b0;
    quad_b = 1'b0;
    ill0 = illPulses;
    @(negedge clk);
    rst_n = 1'b1;
    modelAb = 2'b00;
    modelPos = POS_INIT;
    modelDir = 1'b0;
    modelErr = 0;
    repeat (30) @(negedge clk);
    total++;
    if (pos_live !== POS_W'(POS_INIT) || illPulses !== ill0) begin
      bad++;
      $display("[TB] FAIL midop_release: pos_live=%0d ill=%0d want=%0d,0", pos_live, illPulses - ill0, POS_INIT);
    end
  endtask

  task automatic test_up_steps;
    do_step(2'b01, 20);
    do_step(2'b11, 20);
    do_step(2'b10, 20);
    do_step(2'b00, 20);
    total++;
    if (paddle_pos !== POS_W'(POS_INIT)) begin
      bad++;
      $display("[TB] FAIL paddle_hold: paddle=%0d want=%0d", paddle_pos, POS_INIT);
    end
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    total++;
    if (paddle_pos !== POS_W'(modelPos) || pos_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL frame_snap: paddle=%0d valid=%0b want=%0d,1", paddle_pos, pos_valid, modelPos);
    end
    @(negedge clk);
    total++;
    if (pos_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL valid_pulse: valid=%0b want=0", pos_valid);
    end
  endtask

  task automatic test_glitch;
    int ill0;
    ill0 = illPulses;
    quad_a = ~modelAb[1];
    repeat (3) @(negedge clk);
    quad_a = modelAb[1];
    repeat (20) @(negedge clk);
    total++;
    if (pos_live !== POS_W'(modelPos) || illPulses !== ill0) begin
      bad++;
      $display("[TB] FAIL glitch: pos_live=%0d ill=%0d want=%0d,0", pos_live, illPulses - ill0, modelPos);
    end
    do_step(upSeq[(seq_idx(modelAb) + 3) % 4], 14);
  endtask

  task automatic test_illegal;
    do_step(modelAb ^ 2'b11, 12);
    do_step(modelAb ^ 2'b11, 12);
`ifdef QUAD_ERR_CNT_EN
    for (int i = 0; i < 300; i++) do_step(modelAb ^ 2'b11, 10);
    total++;
    if (err_count !== 8'd255) begin
      bad++;
      $display("[TB] FAIL err_saturate: got=%0d want=255", err_count);
    end
`endif
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 30; i++) do_step(upSeq[(seq_idx(modelAb) + 1) % 4], 10);
    total++;
    if (pos_live !== POS_W'(POS_MAX)) begin
      bad++;
      $display("[TB] FAIL sat_max: pos_live=%0d want=%0d", pos_live, POS_MAX);
    end
    for (int i = 0; i < 50; i++) do_step(upSeq[(seq_idx(modelAb) + 3) % 4], 10);
    total++;
    if (pos_live !== POS_W'(POS_MIN)) begin
      bad++;
      $display("[TB] FAIL sat_min: pos_live=%0d want=%0d", pos_live, POS_MIN);
    end
    do_step(upSeq[(seq_idx(modelAb) + 1) % 4], 10);
  endtask

  task automatic test_frame_edge;
    int oldPos;
    logic [1:0] nxt;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    oldPos = modelPos;
    nxt = upSeq[(seq_idx(modelAb) + 1) % 4];
    modelPos = (modelPos + STEP > POS_MAX) ? POS_MAX : modelPos + STEP;
    modelDir = 1'b1;
    modelAb = nxt;
    quad_a = nxt[1];
    quad_b = nxt[0];
    repeat (LAT) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    total++;
    if (pos_live !== POS_W'(modelPos) || paddle_pos !== POS_W'(oldPos) || pos_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL same_edge: live=%0d paddle=%0d valid=%0b want=%0d,%0d,1",
               pos_live, paddle_pos, pos_valid, modelPos, oldPos);
    end
    repeat (5) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    total++;
    if (paddle_pos !== POS_W'(modelPos) || pos_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL next_snap: paddle=%0d valid=%0b want=%0d,1", paddle_pos, pos_valid, modelPos);
    end
    @(negedge clk);
    frame_tick = 1'b0;
    total++;
    if (pos_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL back_to_back: valid=%0b want=1", pos_valid);
    end
    @(negedge clk);
    total++;
    if (pos_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL b2b_end: valid=%0b want=0", pos_valid);
    end
  endtask

  task automatic test_random;
    int r;
    logic [1:0] nxt;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) nxt = upSeq[(seq_idx(modelAb) + 1) % 4];
      else if (r < 8) nxt = upSeq[(seq_idx(modelAb) + 3) % 4];
      else nxt = modelAb ^ 2'b11;
      do_step(nxt, $urandom_range(10, 18));
      if ($urandom_range(0, 3) == 0) begin
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        total++;
        if (paddle_pos !== POS_W'(modelPos) || pos_valid !== 1'b1) begin
          bad++;
          $display("[TB] FAIL rand_snap: paddle=%0d valid=%0b want=%0d,1", paddle_pos, pos_valid, modelPos);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_midop();
    test_up_steps();
    test_glitch();
    test_illegal();
    test_saturation();
    test_frame_edge();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
